// File: rtl/modulo_captura_jogada_pkg.sv
// Game constants shared by the shot-capture stage: board size, attack mode, FSM encoding
// and the board index helpers.
package modulo_captura_jogada_pkg;

    localparam int unsigned LINHAS  = 7;
    localparam int unsigned COLUNAS = 5;
    localparam int unsigned CELULAS = LINHAS * COLUNAS;

    localparam logic [1:0] MODE_ATAQUE = 2'b10;

    typedef enum logic [1:0] {
        OCIOSO,
        FILTRA_PRESS,
        PRESSIONADO,
        FILTRA_SOLTA
    } estado_t;

    function automatic logic coord_valida(input logic [2:0] linha, input logic [2:0] coluna);
        return (linha >= 3'd1) && (linha <= 3'(LINHAS)) &&
               (coluna >= 3'd1) && (coluna <= 3'(COLUNAS));
    endfunction

    // Only meaningful when coord_valida() holds; out-of-range inputs wrap harmlessly.
    function automatic logic [5:0] cell_index(input logic [2:0] linha, input logic [2:0] coluna);
        logic [5:0] l;
        logic [5:0] c;
        l = {3'b000, linha} - 6'd1;
        c = {3'b000, coluna} - 6'd1;
        return (l * 6'(COLUNAS)) + c;
    endfunction

endpackage

// File: rtl/modulo_debounce.sv
// Fire-button synchroniser and debounce FSM; emits one press_ok pulse per confirmed press.
module modulo_debounce
    import modulo_captura_jogada_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic clr,
    input  logic button_n,
    output logic press_ok,
    output logic busy
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic sync1, sync2;
    logic press;
    estado_t estado, estado_prox;
    logic [CNT_W-1:0] cnt, cnt_prox;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= button_n;
            sync2 <= sync1;
        end
    end

    assign press = ~sync2;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            estado <= OCIOSO;
            cnt    <= '0;
        end else begin
            estado <= estado_prox;
            cnt    <= cnt_prox;
        end
    end

    always_comb begin
        estado_prox = estado;
        cnt_prox    = cnt;
        press_ok    = 1'b0;
        unique case (estado)
            OCIOSO: begin
                if (press) begin
                    cnt_prox    = '0;
                    estado_prox = FILTRA_PRESS;
                end
            end
            FILTRA_PRESS: begin
                if (!press) begin
                    estado_prox = OCIOSO;
                end else if (cnt == CNT_MAX) begin
                    press_ok    = 1'b1;
                    estado_prox = PRESSIONADO;
                end else begin
                    cnt_prox = cnt + CNT_W'(1);
                end
            end
            PRESSIONADO: begin
                if (!press) begin
                    cnt_prox    = '0;
                    estado_prox = FILTRA_SOLTA;
                end
            end
            FILTRA_SOLTA: begin
                if (press) begin
                    estado_prox = PRESSIONADO;
                end else if (cnt == CNT_MAX) begin
                    estado_prox = OCIOSO;
                end else begin
                    cnt_prox = cnt + CNT_W'(1);
                end
            end
            default: estado_prox = OCIOSO;
        endcase
    end

    assign busy = (estado != OCIOSO);

endmodule

// File: rtl/modulo_captura_jogada.sv
// Shot capture: debounced fire press samples the coordinates, validates them against the
// board and tracks fired cells and the accepted-shot count.
module modulo_captura_jogada #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter logic [1:0]  MODE_ATAQUE     = modulo_captura_jogada_pkg::MODE_ATAQUE
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       button_n,
    input  logic [1:0] hh1,
    input  logic [5:0] hh2,
    output logic       shot_valid,
    output logic       shot_repeat,
    output logic       shot_invalid,
    output logic [2:0] shot_line,
    output logic [2:0] shot_col,
    output logic [5:0] shot_count,
    output logic       busy
);

    import modulo_captura_jogada_pkg::*;

    logic               press_ok;
    logic [CELULAS-1:0] fired;
    logic [63:0]        fired_ext;
    logic [CELULAS-1:0] mask;
    logic [2:0]         linha, coluna;
    logic [5:0]         idx;
    logic               in_range, ja_disparado, mode_ok;

    modulo_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .clr      (clr),
        .button_n (button_n),
        .press_ok (press_ok),
        .busy     (busy)
    );

    // Zero-extended so an out-of-range idx never selects past the map.
    assign fired_ext = {{(64 - CELULAS){1'b0}}, fired};

    always_comb begin
        linha        = hh2[5:3];
        coluna       = hh2[2:0];
        in_range     = coord_valida(linha, coluna);
        idx          = cell_index(linha, coluna);
        ja_disparado = fired_ext[idx];
        mask         = {{(CELULAS - 1){1'b0}}, 1'b1} << idx;
        mode_ok      = (hh1 == MODE_ATAQUE);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            shot_valid   <= 1'b0;
            shot_repeat  <= 1'b0;
            shot_invalid <= 1'b0;
            shot_line    <= '0;
            shot_col     <= '0;
            shot_count   <= '0;
            fired        <= '0;
        end else begin
            shot_valid   <= 1'b0;
            shot_repeat  <= 1'b0;
            shot_invalid <= 1'b0;
            if (press_ok) begin
                shot_line <= linha;
                shot_col  <= coluna;
                if (mode_ok) begin
                    if (!in_range) begin
                        shot_invalid <= 1'b1;
                    end else if (ja_disparado) begin
                        shot_repeat <= 1'b1;
                    end else begin
                        shot_valid <= 1'b1;
                        fired      <= fired | mask;
                        if (shot_count != 6'(CELULAS)) begin
                            shot_count <= shot_count + 6'd1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_modulo_captura_jogada.sv
// Directed bench for the shot-capture stage with a small board model and an expectation queue.
module tb_modulo_captura_jogada;

    localparam int unsigned DB = 4;
    localparam int unsigned LAT = 7;

    logic       clk = 1'b0;
    logic       clr;
    logic       button_n;
    logic [1:0] hh1;
    logic [5:0] hh2;
    logic       shot_valid, shot_repeat, shot_invalid;
    logic [2:0] shot_line, shot_col;
    logic [5:0] shot_count;
    logic       busy;

    modulo_captura_jogada #(
        .DEBOUNCE_CYCLES(DB),
        .MODE_ATAQUE    (2'b10)
    ) dut (
        .clk          (clk),
        .clr          (clr),
        .button_n     (button_n),
        .hh1          (hh1),
        .hh2          (hh2),
        .shot_valid   (shot_valid),
        .shot_repeat  (shot_repeat),
        .shot_invalid (shot_invalid),
        .shot_line    (shot_line),
        .shot_col     (shot_col),
        .shot_count   (shot_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // kind: 0 none, 1 valid, 2 repeat, 3 invalid
    typedef struct {
        logic [1:0] kind;
        logic [2:0] line;
        logic [2:0] col;
    } exp_t;

    exp_t        sb[$];
    exp_t        g_e;
    logic [34:0] m_fired;
    int          m_count;
    int          checks = 0;
    int          failures = 0;
    int          g_strobes;
    bit          g_got;
    int          n_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    function automatic logic [1:0] obs_kind();
        if (shot_valid) return 2'd1;
        if (shot_repeat) return 2'd2;
        if (shot_invalid) return 2'd3;
        return 2'd0;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_strobes"}, {29'd0, shot_valid, shot_repeat, shot_invalid}, 32'd0);
        check({tag, "_line"}, {29'd0, shot_line}, 32'd0);
        check({tag, "_col"}, {29'd0, shot_col}, 32'd0);
        check({tag, "_count"}, {26'd0, shot_count}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_fired"}, {29'd0, dut.fired[34:32]} | 32'(dut.fired[31:0] != 0), 32'd0);
    endtask

    task automatic push_expect(input logic [2:0] l, input logic [2:0] c);
        exp_t e;
        int   li, ci, idx;
        li = int'(l);
        ci = int'(c);
        e.line = l;
        e.col  = c;
        if (hh1 != 2'b10) begin
            e.kind = 2'd0;
        end else if (li < 1 || li > 7 || ci < 1 || ci > 5) begin
            e.kind = 2'd3;
        end else begin
            idx = (li - 1) * 5 + (ci - 1);
            if (m_fired[idx]) begin
                e.kind = 2'd2;
            end else begin
                e.kind = 2'd1;
                m_fired[idx] = 1'b1;
                if (m_count < 35) m_count++;
            end
        end
        sb.push_back(e);
    endtask

    task automatic press_start(input logic [2:0] l, input logic [2:0] c);
        @(negedge clk);
        hh2 = {l, c};
        push_expect(l, c);
        button_n = 1'b0;
        g_got = 1'b0;
        g_strobes = 0;
    endtask

    task automatic watch(input int hold);
        for (int i = 1; i <= hold; i++) begin
            @(posedge clk);
            #1;
            if (shot_valid || shot_repeat || shot_invalid) begin
                g_strobes++;
                if (shot_valid) n_valid++;
                check("strobe_onehot", $countones({shot_valid, shot_repeat, shot_invalid}), 1);
                if (!g_got && sb.size() > 0) begin
                    g_e = sb.pop_front();
                    g_got = 1'b1;
                    check("kind", {30'd0, obs_kind()}, {30'd0, g_e.kind});
                    check("line", {29'd0, shot_line}, {29'd0, g_e.line});
                    check("col", {29'd0, shot_col}, {29'd0, g_e.col});
                    check("latency", i, LAT);
                end
            end
        end
    endtask

    task automatic press_end(input logic [2:0] l, input logic [2:0] c);
        int k;
        @(negedge clk);
        button_n = 1'b1;
        hh2 = 6'b111_111;
        k = 0;
        while (busy && k < 40) begin
            @(posedge clk);
            #1;
            if (shot_valid || shot_repeat || shot_invalid) g_strobes++;
            k++;
        end
        check("busy_idle", {31'd0, busy}, 32'd0);
        if (!g_got) begin
            if (sb.size() > 0) g_e = sb.pop_front();
            check("kind_none", 32'd0, {30'd0, g_e.kind});
        end
        check("strobe_count", g_strobes, (g_e.kind != 2'd0) ? 1 : 0);
        check("line_hold", {29'd0, shot_line}, {29'd0, l});
        check("col_hold", {29'd0, shot_col}, {29'd0, c});
        check("count", {26'd0, shot_count}, m_count);
        check("fired_map", {29'd0, dut.fired[34:32]}, {29'd0, m_fired[34:32]});
        check("fired_map_lo", dut.fired[31:0], m_fired[31:0]);
    endtask

    task automatic do_press(input logic [2:0] l, input logic [2:0] c);
        press_start(l, c);
        watch(10);
        press_end(l, c);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        #1;
        check_reset_outputs("clr");
        m_fired = '0;
        m_count = 0;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        int k;
        clr = 1'b1;
        button_n = 1'b1;
        hh1 = 2'b10;
        hh2 = 6'd0;
        m_fired = '0;
        m_count = 0;
        n_valid = 0;
        g_e.kind = 2'd0;
        g_e.line = 3'd0;
        g_e.col = 3'd0;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;

        // Clean press, line 3 column 2.
        do_press(3'd3, 3'd2);
        check("fired11", {31'd0, dut.fired[11]}, 32'd1);

        // Bounce: low/high every 2 cycles never survives the filter.
        g_strobes = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            button_n = (i % 4) >= 2;
            @(posedge clk);
            #1;
            if (shot_valid || shot_repeat || shot_invalid) g_strobes++;
        end
        @(negedge clk);
        button_n = 1'b1;
        k = 0;
        while (busy && k < 40) begin
            @(posedge clk);
            #1;
            if (shot_valid || shot_repeat || shot_invalid) g_strobes++;
            k++;
        end
        check("bounce_strobes", g_strobes, 0);
        check("bounce_busy", {31'd0, busy}, 32'd0);
        check("bounce_count", {26'd0, shot_count}, m_count);

        // Repeat shot and out-of-range coordinates.
        do_press(3'd3, 3'd2);
        do_press(3'd0, 3'd3);
        do_press(3'd7, 3'd6);

        // Mode gate: coordinates still captured, no strobe.
        hh1 = 2'b01;
        do_press(3'd2, 3'd2);
        hh1 = 2'b10;

        // Reset while the button is held in PRESSIONADO.
        press_start(3'd1, 3'd1);
        watch(9);
        check("pre_clr_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        clr = 1'b1;
        #1;
        check_reset_outputs("midclr");
        m_fired = '0;
        m_count = 0;
        sb.delete();
        push_expect(3'd1, 3'd1);
        g_got = 1'b0;
        g_strobes = 0;
        @(negedge clk);
        clr = 1'b0;
        watch(10);
        press_end(3'd1, 3'd1);

        // Saturation: every cell once, then one more on a fired cell.
        pulse_clr();
        n_valid = 0;
        for (int l = 1; l <= 7; l++) begin
            for (int c = 1; c <= 5; c++) begin
                do_press(3'(l), 3'(c));
            end
        end
        check("valid_total", n_valid, 35);
        do_press(3'd4, 3'd4);
        check("sat_count", {26'd0, shot_count}, 32'd35);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
